// File: rtl/rv_pipe_pkg.sv
// Shared types and encodings for the 5-stage pipeline hazard/control unit.
package rv_pipe_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    // Stage in which taken branches are resolved
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;

    // Width of the rd field held in the shadow entries; register-address
    // widths up to this value are zero-extended into it.
    localparam int RD_W = 8;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } shadow_t;

    // Pipeline action chosen for the current cycle
    typedef enum logic [1:0] {
        ADV_HOLD   = 2'b00,
        ADV_BRANCH = 2'b01,
        ADV_HAZARD = 2'b10,
        ADV_NORMAL = 2'b11
    } adv_e;

    // A shadowed producer writes the register a consumer reads; x0 never counts.
    function automatic logic producer_match(input shadow_t p,
                                            input logic [RD_W-1:0] src,
                                            input logic use_src);
        return p.valid && p.regwrite && (p.rd != {RD_W{1'b0}}) &&
               (p.rd == src) && use_src;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source register.
module fwd_select
    import rv_pipe_pkg::*;
#(
    parameter int FWD_EN = 1
)(
    input  logic            ex_valid,
    input  logic [RD_W-1:0] src,
    input  shadow_t         mem,
    input  shadow_t         wb,
    output logic [1:0]      fwd
);

    // Newer EX/MEM producer wins over MEM/WB; x0 and unread sources never forward.
    always_comb begin
        fwd = FWD_REGFILE;
        if ((FWD_EN == 0) || !ex_valid) begin
            fwd = FWD_REGFILE;
        end else if (producer_match(mem, src, 1'b1)) begin
            fwd = FWD_EXMEM;
        end else if (producer_match(wb, src, 1'b1)) begin
            fwd = FWD_MEMWB;
        end else begin
            fwd = FWD_REGFILE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, pipeline enables/flushes, forwarding and perf counters
// for the 5-stage core. Shadows ID/EX/MEM/WB producer information.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int REGA         = 5,
    parameter int FWD_EN       = 1,
    parameter int WB_BYPASS    = 1,
    parameter int BRANCH_STAGE = 3,
    parameter int CNTW         = 32
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            ext_stall,
    input  logic            if_valid,
    input  logic [REGA-1:0] id_rs1,
    input  logic [REGA-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGA-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            branch_taken,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            id_valid,
    output logic            ex_valid,
    output logic            mem_valid,
    output logic            wb_valid,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    logic            id_valid_r;
    shadow_t         ex_r;
    shadow_t         mem_r;
    shadow_t         wb_r;
    logic [RD_W-1:0] ex_rs1_r;
    logic [RD_W-1:0] ex_rs2_r;
    logic [CNTW-1:0] stall_cnt_r;
    logic [CNTW-1:0] flush_cnt_r;

    logic [RD_W-1:0] id_rs1_s;
    logic [RD_W-1:0] id_rs2_s;
    shadow_t         id_entry_s;
    logic            ex_hit_s;
    logic            mem_hit_s;
    logic            wb_hit_s;
    logic            hazard_s;
    adv_e            adv_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    // Sources the instruction does not read are stored as x0, so they can never match.
    assign id_rs1_s   = id_use_rs1 ? RD_W'(id_rs1) : {RD_W{1'b0}};
    assign id_rs2_s   = id_use_rs2 ? RD_W'(id_rs2) : {RD_W{1'b0}};
    assign id_entry_s = '{valid: 1'b1, rd: RD_W'(id_rd),
                          regwrite: id_regwrite, memread: id_memread};

    // RAW hazard of the ID instruction against older in-flight producers.
    always_comb begin
        ex_hit_s  = producer_match(ex_r,  id_rs1_s, id_use_rs1) || producer_match(ex_r,  id_rs2_s, id_use_rs2);
        mem_hit_s = producer_match(mem_r, id_rs1_s, id_use_rs1) || producer_match(mem_r, id_rs2_s, id_use_rs2);
        wb_hit_s  = producer_match(wb_r,  id_rs1_s, id_use_rs1) || producer_match(wb_r,  id_rs2_s, id_use_rs2);
        hazard_s  = 1'b0;
        if (!id_valid_r) begin
            hazard_s = 1'b0;
        end else if (FWD_EN != 0) begin
            hazard_s = ex_hit_s && ex_r.memread;
        end else begin
            hazard_s = ex_hit_s || mem_hit_s || ((WB_BYPASS == 0) && wb_hit_s);
        end
    end

    // Choose the cycle's action (branch > hazard > normal) and drive enables/flushes.
    always_comb begin
        adv_s        = ADV_HOLD;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (ext_stall) begin
            adv_s = ADV_HOLD;
        end else if (branch_taken) begin
            adv_s        = ADV_BRANCH;
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = (BRANCH_STAGE == STAGE_MEM);
        end else if (hazard_s) begin
            adv_s       = ADV_HAZARD;
            id_ex_flush = 1'b1;
        end else begin
            adv_s    = ADV_NORMAL;
            pc_en    = 1'b1;
            if_id_en = 1'b1;
        end
    end

    // Shadow pipeline state and performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid_r  <= 1'b0;
            ex_r        <= '0;
            mem_r       <= '0;
            wb_r        <= '0;
            ex_rs1_r    <= {RD_W{1'b0}};
            ex_rs2_r    <= {RD_W{1'b0}};
            stall_cnt_r <= {CNTW{1'b0}};
            flush_cnt_r <= {CNTW{1'b0}};
        end else begin
            case (adv_s)
                ADV_NORMAL: begin
                    id_valid_r <= if_valid;
                    if (id_valid_r) begin
                        ex_r     <= id_entry_s;
                        ex_rs1_r <= id_rs1_s;
                        ex_rs2_r <= id_rs2_s;
                    end else begin
                        ex_r.valid <= 1'b0;
                    end
                    mem_r <= ex_r;
                    wb_r  <= mem_r;
                end
                ADV_HAZARD: begin
                    ex_r.valid  <= 1'b0;
                    mem_r       <= ex_r;
                    wb_r        <= mem_r;
                    stall_cnt_r <= sat_inc(stall_cnt_r);
                end
                ADV_BRANCH: begin
                    id_valid_r  <= 1'b0;
                    ex_r.valid  <= 1'b0;
                    mem_r       <= ex_r;
                    mem_r.valid <= (BRANCH_STAGE == STAGE_MEM) ? 1'b0 : ex_r.valid;
                    wb_r        <= mem_r;
                    flush_cnt_r <= sat_inc(flush_cnt_r);
                end
                ADV_HOLD: begin
                    id_valid_r <= id_valid_r;
                end
                default: begin
                    id_valid_r <= id_valid_r;
                end
            endcase
        end
    end

    fwd_select #(.FWD_EN(FWD_EN)) u_fwd_a (
        .ex_valid (ex_r.valid),
        .src      (ex_rs1_r),
        .mem      (mem_r),
        .wb       (wb_r),
        .fwd      (fwd_a)
    );

    fwd_select #(.FWD_EN(FWD_EN)) u_fwd_b (
        .ex_valid (ex_r.valid),
        .src      (ex_rs2_r),
        .mem      (mem_r),
        .wb       (wb_r),
        .fwd      (fwd_b)
    );

    assign id_valid  = id_valid_r;
    assign ex_valid  = ex_r.valid;
    assign mem_valid = mem_r.valid;
    assign wb_valid  = wb_r.valid;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl.
// DUT a: FWD_EN=1, WB_BYPASS=1, BRANCH_STAGE=3, CNTW=32.
// DUT b: FWD_EN=0, WB_BYPASS=1, BRANCH_STAGE=2, CNTW=2 (to reach saturation).
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        logic       stall;
        logic       ifv;
        logic       br;
        instr_t     ins;
        logic [4:0] ctl;   // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] vld;   // {id, ex, mem, wb}
        int         sc;
        int         fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset, ext_stall, if_valid, branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_use_rs1, id_use_rs2, id_regwrite, id_memread;

    logic a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush;
    logic [1:0] a_fwd_a, a_fwd_b;
    logic a_id_valid, a_ex_valid, a_mem_valid, a_wb_valid;
    logic [31:0] a_stall_cnt, a_flush_cnt;

    logic b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush;
    logic [1:0] b_fwd_a, b_fwd_b;
    logic b_id_valid, b_ex_valid, b_mem_valid, b_wb_valid;
    logic [1:0] b_stall_cnt, b_flush_cnt;

    int applied = 0;
    int miscompares = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REGA(5), .FWD_EN(1), .WB_BYPASS(1), .BRANCH_STAGE(3), .CNTW(32)) dut_a (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush),
        .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
        .id_valid(a_id_valid), .ex_valid(a_ex_valid), .mem_valid(a_mem_valid), .wb_valid(a_wb_valid),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.REGA(5), .FWD_EN(0), .WB_BYPASS(1), .BRANCH_STAGE(2), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush),
        .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
        .id_valid(b_id_valid), .ex_valid(b_ex_valid), .mem_valid(b_mem_valid), .wb_valid(b_wb_valid),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2, input logic rw, input logic mr);
        instr_t t;
        t.rd = rd; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rw = rw; t.mr = mr;
        return t;
    endfunction

    task automatic add_vec(input logic stall, input logic ifv, input logic br, input instr_t ins,
                           input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [3:0] vld, input int sc, input int fc);
        vec_t v;
        v.stall = stall; v.ifv = ifv; v.br = br; v.ins = ins; v.ctl = ctl;
        v.fa = fa; v.fb = fb; v.vld = vld; v.sc = sc; v.fc = fc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic stall, input logic ifv, input logic br, input instr_t ins);
        ext_stall = stall; if_valid = ifv; branch_taken = br;
        id_rd = ins.rd; id_rs1 = ins.rs1; id_use_rs1 = ins.u1;
        id_rs2 = ins.rs2; id_use_rs2 = ins.u2; id_regwrite = ins.rw; id_memread = ins.mr;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [3:0] vld, input int sc, input int fc);
        applied++;
        cmp({tag, " a.ctl"}, 32'({a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush}), 32'(ctl));
        cmp({tag, " a.fwd_a"}, 32'(a_fwd_a), 32'(fa));
        cmp({tag, " a.fwd_b"}, 32'(a_fwd_b), 32'(fb));
        cmp({tag, " a.valid"}, 32'({a_id_valid, a_ex_valid, a_mem_valid, a_wb_valid}), 32'(vld));
        cmp({tag, " a.stall_cnt"}, a_stall_cnt, 32'(sc));
        cmp({tag, " a.flush_cnt"}, a_flush_cnt, 32'(fc));
    endtask

    task automatic check_b(input string tag, input logic [4:0] ctl, input logic [4:0] mask,
                           input logic [3:0] vld, input int sc, input int fc);
        logic [4:0] act_ctl;
        applied++;
        act_ctl = {b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush};
        cmp({tag, " b.ctl"}, 32'(act_ctl & mask), 32'(ctl & mask));
        cmp({tag, " b.fwd"}, 32'({b_fwd_a, b_fwd_b}), 32'(4'b0000));
        cmp({tag, " b.valid"}, 32'({b_id_valid, b_ex_valid, b_mem_valid, b_wb_valid}), 32'(vld));
        cmp({tag, " b.stall_cnt"}, 32'(b_stall_cnt), 32'(sc));
        cmp({tag, " b.flush_cnt"}, 32'(b_flush_cnt), 32'(fc));
    endtask

    task automatic step_b(input string tag, input logic ifv, input logic br, input instr_t ins,
                          input logic [4:0] ctl, input logic [3:0] vld, input int sc, input int fc);
        drive(1'b0, ifv, br, ins);
        #1;
        check_b(tag, ctl, 5'b11111, vld, sc, fc);
        @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t nop, ld5, add6, add5, sub8, add9, or10, and13, x0p, add14, add15a, add15b;
        instr_t sub16, ld17, add18, ld20, add21, add6x, add7, add9b;
        logic [4:0] N, H, HOLD, BR3, BR2, RST_A, RST_B;
        N = 5'b11000; H = 5'b00010; HOLD = 5'b00000; BR3 = 5'b11111; BR2 = 5'b11110;
        RST_A = 5'b00111; RST_B = 5'b00110;

        //            rd      rs1 u1     rs2 u2 rw mr
        nop    = mk(5'd0,  5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ld5    = mk(5'd5,  5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        add6   = mk(5'd6,  5'd5, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
        add5   = mk(5'd5,  5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        sub8   = mk(5'd8,  5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        add9   = mk(5'd9,  5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        or10   = mk(5'd10, 5'd11, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
        and13  = mk(5'd13, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        x0p    = mk(5'd0,  5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        add14  = mk(5'd14, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        add15a = mk(5'd15, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        add15b = mk(5'd15, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        sub16  = mk(5'd16, 5'd15, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        ld17   = mk(5'd17, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        add18  = mk(5'd18, 5'd17, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        ld20   = mk(5'd20, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        add21  = mk(5'd21, 5'd20, 1'b1, 5'd20, 1'b1, 1'b1, 1'b0);
        add6x  = mk(5'd6,  5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        add7   = mk(5'd7,  5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        add9b  = mk(5'd9,  5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);

        // Table for DUT a: stall ifv br  instr   ctl   fa     fb     {id,ex,mem,wb} sc fc
        add_vec(1'b0, 1'b1, 1'b0, nop,    N,    2'b00, 2'b00, 4'b0000, 0, 0);
        add_vec(1'b0, 1'b1, 1'b0, ld5,    N,    2'b00, 2'b00, 4'b1000, 0, 0);
        add_vec(1'b0, 1'b1, 1'b0, add6,   H,    2'b00, 2'b00, 4'b1100, 0, 0); // load-use
        add_vec(1'b0, 1'b1, 1'b0, add6,   N,    2'b00, 2'b00, 4'b1010, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, add5,   N,    2'b01, 2'b00, 4'b1101, 1, 0); // add gets ld via WB
        add_vec(1'b0, 1'b1, 1'b0, sub8,   N,    2'b00, 2'b00, 4'b1110, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, add9,   N,    2'b10, 2'b10, 4'b1111, 1, 0); // back-to-back ALU
        add_vec(1'b0, 1'b1, 1'b0, or10,   N,    2'b00, 2'b00, 4'b1111, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, and13,  N,    2'b00, 2'b00, 4'b1111, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, x0p,    N,    2'b01, 2'b01, 4'b1111, 1, 0); // one gap
        add_vec(1'b0, 1'b1, 1'b0, add14,  N,    2'b00, 2'b00, 4'b1111, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, add15a, N,    2'b00, 2'b00, 4'b1111, 1, 0); // x0 not forwarded
        add_vec(1'b0, 1'b1, 1'b0, add15b, N,    2'b00, 2'b00, 4'b1111, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, sub16,  N,    2'b00, 2'b00, 4'b1111, 1, 0);
        add_vec(1'b0, 1'b1, 1'b0, ld17,   N,    2'b10, 2'b00, 4'b1111, 1, 0); // MEM beats WB
        add_vec(1'b0, 1'b1, 1'b1, add18,  BR3,  2'b00, 2'b00, 4'b1111, 1, 0); // branch over load-use
        add_vec(1'b0, 1'b1, 1'b0, nop,    N,    2'b00, 2'b00, 4'b0001, 1, 1);
        add_vec(1'b0, 1'b1, 1'b0, ld20,   N,    2'b00, 2'b00, 4'b1000, 1, 1);
        for (int k = 0; k < 4; k++)
            add_vec(1'b1, 1'b1, 1'b0, add21, HOLD, 2'b00, 2'b00, 4'b1100, 1, 1); // frozen
        add_vec(1'b0, 1'b1, 1'b0, add21,  H,    2'b00, 2'b00, 4'b1100, 1, 1);
        add_vec(1'b0, 1'b0, 1'b0, add21,  N,    2'b00, 2'b00, 4'b1010, 2, 1);
        add_vec(1'b0, 1'b1, 1'b0, nop,    N,    2'b01, 2'b01, 4'b0101, 2, 1);

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, nop);
        repeat (2) @(negedge clk);
        check_a("reset", RST_A, 2'b00, 2'b00, 4'b0000, 0, 0);
        check_b("reset", RST_B, 5'b11110, 4'b0000, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].ifv, vecs[i].br, vecs[i].ins);
            #1;
            check_a($sformatf("v%0d", i), vecs[i].ctl, vecs[i].fa, vecs[i].fb,
                    vecs[i].vld, vecs[i].sc, vecs[i].fc);
            @(negedge clk);
        end

        // Stall-on-any-RAW configuration, counter saturation, async reset mid-stall.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, nop);
        #1;
        check_b("b_reset", RST_B, 5'b11110, 4'b0000, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step_b("b0", 1'b1, 1'b0, nop,   N, 4'b0000, 0, 0);
        step_b("b1", 1'b1, 1'b0, add5,  N, 4'b1000, 0, 0);
        step_b("b2", 1'b1, 1'b0, add6x, H, 4'b1100, 0, 0);
        step_b("b3", 1'b1, 1'b0, add6x, H, 4'b1010, 1, 0);
        step_b("b4", 1'b1, 1'b0, add6x, N, 4'b1001, 2, 0);
        step_b("b5", 1'b1, 1'b0, add7,  H, 4'b1100, 2, 0);
        step_b("b6", 1'b1, 1'b0, add7,  H, 4'b1010, 3, 0);
        step_b("b7", 1'b1, 1'b0, add7,  N, 4'b1001, 3, 0); // saturated at 3
        drive(1'b0, 1'b1, 1'b0, add9b);
        #1;
        check_b("b8", H, 5'b11111, 4'b1100, 3, 0);
        #1;
        reset = 1'b0;
        #1;
        check_b("b8_async_rst", RST_B, 5'b11110, 4'b0000, 0, 0);
        check_a("a_async_rst", RST_A, 2'b00, 2'b00, 4'b0000, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step_b("b9",  1'b1, 1'b0, nop,  N,   4'b0000, 0, 0);
        step_b("b10", 1'b1, 1'b1, add5, BR2, 4'b1000, 0, 0);
        step_b("b11", 1'b1, 1'b0, nop,  N,   4'b0000, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage RV64 core. It shadows the destination, register-write and load information of every in-flight instruction in the ID/EX, EX/MEM and MEM/WB stages. From that state it generates PC/IF-ID enables, bubble/flush strobes and EX operand-forwarding selects. It adds stall, flush, forwarding and performance counting, which the current flat pipeline-register top level lacks. The top level gates its pipeline registers with these outputs.

Parameters:
REGA, 5, register-address width
FWD_EN, 1, 1 = forwarding with load-use stall; 0 = stall on any RAW
WB_BYPASS, 1, 1 = regfile writes through to same-cycle reads (WB stage never a hazard source)
BRANCH_STAGE, 3, stage resolving branches: 2 = EX, 3 = MEM
CNTW, 32, width of performance counters

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
ext_stall  in  1  data/instr memory not ready; freezes whole pipe
if_valid  in  1  fetch presents a valid instruction
id_rs1, id_rs2  in  REGA  source registers decoded in ID
id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
id_rd  in  REGA  destination in ID
id_regwrite, id_memread  in  1  control bits of the instruction in ID
branch_taken  in  1  taken branch resolved in BRANCH_STAGE
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID load NOP
id_ex_flush  out  1  ID/EX load bubble (control bits zero)
ex_mem_flush  out  1  EX/MEM load bubble (only BRANCH_STAGE=3)
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
id_valid, ex_valid, mem_valid, wb_valid  out  1  stage valid bits
stall_cnt, flush_cnt  out  CNTW  saturating counters: hazard-stall cycles, flush events

Behaviour:
- Reset (reset low, asynchronous): all valids 0, shadow rd/rs 0, counters 0. While reset is low, enables are 0, flush strobes are 1 and fwd are 00.
- Shadow state:
  - ID: id_valid.
  - EX: valid, rd, rs1, rs2, regwrite, memread.
  - MEM: valid, rd, regwrite, memread.
  - WB: valid, rd, regwrite.
- A producer matches src when: valid && regwrite && rd!=0 && rd==src && use_src.
- Advance cycle = ext_stall low. With ext_stall high: every enable is 0, flushes are 0, all state holds, counters hold, and branch_taken is ignored (the source holds it until advance).
- Priority on an advance cycle is branch > hazard > normal.
- Hazard, FWD_EN=1: ID matches an EX producer with memread=1 (load-use). Stall is exactly 1 cycle.
- Hazard, FWD_EN=0: ID matches an EX or MEM producer, or a WB producer when WB_BYPASS=0. The stall repeats until no match.
- Hazard response, same cycle, combinational:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - Next edge: EX shadow gets valid=0 while ID holds; MEM and WB advance.
  - stall_cnt+1.
- Branch taken:
  - BRANCH_STAGE=2: if_id_flush=1 and id_ex_flush=1.
  - BRANCH_STAGE=3: additionally ex_mem_flush=1.
  - pc_en=1 (PC loads target), if_id_en=1.
  - Next edge: the flushed stages' valids become 0.
  - flush_cnt+1.
  - A hazard in the same cycle is discarded.
- Normal advance:
  - pc_en=1, if_id_en=1, flushes 0.
  - Shadows shift ID→EX→MEM→WB.
  - id_valid<=if_valid.
  - The ID->EX shift copies shadow fields only when id_valid.
- Forwarding (FWD_EN=1 only; else fwd=00): combinational from registered shadows.
  - fwd_a=10 if MEM matches ex_rs1, else 01 if WB matches, else 00. fwd_b is the same for ex_rs2.
  - The EX/MEM producer is newer and wins.
  - x0 is never forwarded.
  - fwd is 00 when ex_valid=0.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush clears everything immediately. First advance after release: id_valid<=if_valid, all else bubbles.

Decomposition:
- Shared package (rv_pipe_pkg): FWD_* select encodings (00/01/10), the STAGE_EX=2 / STAGE_MEM=3 constants, and the shadow-entry struct (valid, rd, regwrite, memread).
- One sub-module, fwd_select: purely combinational compare for one operand, instantiated twice. Keeps the priority and x0 rules in one place.

Test Plan:
1. Load-use, FWD_EN=1: ld x5 in EX, ID add x6,x5,x7 → pc_en=0, if_id_en=0 and id_ex_flush=1 for exactly 1 cycle. Next cycle fwd_a=01 for the add in EX. stall_cnt=1.
2. Back-to-back ALU: add x5 then sub x8,x5,x5 → no stall; fwd_a=fwd_b=10 when sub is in EX. Insert one unrelated instruction between them → 01.
3. x0 and priority: producer rd=x0 → fwd=00. Same rd in MEM and WB → 10.
4. Branch, BRANCH_STAGE=3, branch_taken=1 for one cycle → if_id_flush, id_ex_flush and ex_mem_flush all 1. Next cycle id/ex/mem valid=0. flush_cnt=1. A coincident load-use hazard produces no stall count.
5. ext_stall high for 4 cycles with a pending load-use hazard → all outputs frozen and counters unchanged. On release the hazard stall fires once.
6. FWD_EN=0, WB_BYPASS=1: add x5 then add x6,x5,x0 → stall 2 cycles. Pull reset low mid-stall → valids 0 and counters 0 asynchronously.
